// File: rtl/handshaking_rr_arbiter_pkg.sv
// Shared definitions for the handshaking round-robin arbiter.
package handshaking_rr_arbiter_pkg;

    // Arbiter FSM: IDLE picks the next requester, GRANT streams its burst.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin priority select: finds the first set request bit
// starting at ptr and searching upward with wrap. Reusable by other arbiters.
module rr_priority_select #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] sel,
    output logic               any
);

    logic             found;
    logic [PTR_W:0]   pos_sum;
    logic [PTR_W-1:0] pos;

    // Walk the requests in rotated order; the first hit wins.
    always_comb begin
        sel     = '0;
        found   = 1'b0;
        pos_sum = '0;
        pos     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // Explicit modulo by subtraction keeps non-power-of-2 counts correct.
            pos_sum = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (pos_sum >= (PTR_W + 1)'(NUM_REQ)) begin
                pos_sum = pos_sum - (PTR_W + 1)'(NUM_REQ);
            end
            pos = pos_sum[PTR_W-1:0];
            if (!found && req[pos]) begin
                sel[pos] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/handshaking_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel among NUM_REQ requesters.
// Each grant lasts at most BURST_LEN beats; the output side is a registered
// full-throughput stage.
module handshaking_rr_arbiter
    import handshaking_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    input  logic                          out_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    arb_state_e              state_q, state_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

    logic [NUM_REQ-1:0]      pick_sel;
    logic                    pick_any;
    logic [PTR_W-1:0]        gnt_idx;
    logic [PTR_W-1:0]        next_ptr;
    logic [DATA_WIDTH-1:0]   gnt_data;
    logic                    gnt_valid;
    logic                    in_grant;
    logic                    slot_free;
    logic                    accept;
    logic                    last_beat;
    logic                    grant_done;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ)
    ) u_select (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .sel (pick_sel),
        .any (pick_any)
    );

    // Encode the one-hot grant and mux the granted requester's valid/data.
    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                gnt_idx  = PTR_W'(i);
                gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign gnt_valid  = |(req_valid & grant_q);
    assign in_grant   = (state_q == ST_GRANT);
    // Output slot can take a beat if empty or draining this cycle.
    assign slot_free  = ~out_valid_q | out_ready;
    assign req_ready  = in_grant ? (grant_q & {NUM_REQ{slot_free}}) : '0;
    assign accept     = in_grant & gnt_valid & slot_free;
    assign last_beat  = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
    // A dropped valid forfeits the rest of the burst.
    assign grant_done = in_grant & (~gnt_valid | (accept & last_beat));
    assign next_ptr   = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

    // Arbitration FSM next state: pick in IDLE, count and release in GRANT.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_sel;
                    beat_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                if (grant_done) begin
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    // Output register: load on accept, drain on out_ready, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset drops any held beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign grant     = grant_q;
    assign busy      = in_grant;

endmodule

// File: doc/handshaking_rr_arbiter.md
# handshaking_rr_arbiter

Round-robin arbiter that shares one valid/ready handshaking channel among `NUM_REQ` upstream requesters. Each grant is held for a bounded burst of beats, then moves to the next requester in rotation. The output side drives a standard handshaking slave directly. The output side is a registered stage with full throughput: one beat per cycle under no backpressure.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, at least 2.
- `DATA_WIDTH`, 8: beat width.
- `BURST_LEN`, 4: maximum beats per grant, at least 1.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`: per-requester valid.
- `req_data`  in  `NUM_REQ*DATA_WIDTH`: packed data; requester i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready`  out  `NUM_REQ`: per-requester ready.
- `out_valid`  out  1: registered valid toward the slave.
- `out_data`  out  `DATA_WIDTH`: registered data toward the slave.
- `out_ready`  in  1: slave ready.
- `grant`  out  `NUM_REQ`: one-hot current grant; all zero in IDLE.
- `busy`  out  1: high in GRANT state.

## Operation
- State machine:
  - IDLE: if any `req_valid` bit is set, select the first set bit searching from `rr_ptr` upward with wrap. Register it into `grant`, clear `beat_cnt`, go to GRANT. Otherwise stay in IDLE.
  - GRANT: g is the granted index.
    - `req_ready[g] = ~out_valid | out_ready`. All other `req_ready` bits are 0.
    - Accept = `req_valid[g] & req_ready[g]`.
    - On accept: load `out_data` from slice g, set `out_valid`, increment `beat_cnt`.
    - Release on accept with `beat_cnt == BURST_LEN-1`, or when `req_valid[g]` is 0 in any GRANT cycle.
    - On release: `grant` goes to 0, `rr_ptr` becomes (g+1) mod `NUM_REQ`, next state is IDLE.
- Output register, evaluated in the same cycle:
  - On accept: `out_valid` is 1 and `out_data` takes the new beat.
  - Else if `out_ready`: `out_valid` goes to 0.
  - Else: `out_valid` and `out_data` are held.
- `out_data` is never modified while `out_valid & ~out_ready`.
- A requester that drops valid while granted forfeits the remainder of its burst.
- `beat_cnt` width is `$clog2(BURST_LEN+1)`. It never exceeds `BURST_LEN-1` before release and does not wrap.
- `rr_ptr` width is `$clog2(NUM_REQ)`. Wrap is explicit modulo `NUM_REQ`, correct for non-power-of-2 values.
- Reset: state IDLE, `rr_ptr` 0, `grant` 0, `beat_cnt` 0, `out_valid` 0, `out_data` 0, `busy` 0, `req_ready` 0. Reset mid-burst discards the beat held in the output register.

## Timing
- `req_valid` rising in IDLE leads to `grant` and `req_ready` on the next cycle: 1-cycle arbitration latency.
- An accepted beat appears on `out_valid`/`out_data` 1 cycle after the accept.
- Throughput is 1 beat per cycle while `out_ready` is held high.
- Between grants there is one IDLE bubble cycle with no `req_ready`. The last beat of the previous grant may still be presented on `out_*` during this cycle.
- `out_ready` low with `out_valid` high forces `req_ready` to 0 in the same cycle: combinational path from `out_ready` to `req_ready`.
- Simultaneous accept and `out_ready` in one cycle: the old beat leaves and the new beat loads with no gap.
- `req_valid` of non-granted requesters is ignored until the next IDLE cycle.

## Structure
- Shared package: state encoding constants (`ST_IDLE`, `ST_GRANT`). Place it alongside the other handshaking definitions.
- Sub-module `rr_priority_select`: combinational, input `req` and `ptr`, output one-hot `sel` and `any`. It is reusable by other arbiters.
- The output register stage stays inline.

## Test plan
All scenarios use `NUM_REQ`=4, `BURST_LEN`=4, `DATA_WIDTH`=8.

- **Reset values**: Apply `rst` for 2 cycles with all requests active. Required: all outputs are 0 during reset. The first grant is to requester 0, one cycle after `rst` falls.
- **Burst split**: Requester 1 alone streams 0x10..0x15 with `out_ready`=1. Required: 0x10..0x13 are accepted, then `grant` drops for 1 cycle. A re-grant to requester 1 follows, and 0x14, 0x15 are accepted; the grant releases when valid drops. `out_data` shows all 6 values in order.
- **Rotation**: All 4 requesters stream continuously. Required: grant order is 0,1,2,3,0 with 4 beats each. The bench checks each `out_data` beat against its source.
- **Backpressure**: `out_ready`=0 for 5 cycles in mid-burst. Required: `out_valid` and `out_data` are held and `req_ready` is 0. When `out_ready` returns, no beat is lost or duplicated.
- **Early release**: Requester 2 sends 2 beats, then drops valid, while requester 3 is waiting. Required: release occurs with `beat_cnt`=2. The next grant goes to requester 3, and `rr_ptr` is 3.
- **Reset mid-operation**: Assert `rst` while `out_valid`=1 and `out_ready`=0. Required: `out_valid` is 0 on the next cycle, state is IDLE, and `rr_ptr` is 0.
